ahb_sram_slave: RTL

AHB-Lite memory slave that sits directly downstream of the team's AHB-Lite master. It consumes HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA/HWDATACHK and returns HRDATA/HREADY/HRSP. It holds a word-organised SRAM with a programmable number of wait states and byte-lane writes. It checks write-data parity and raises the two-cycle AHB ERROR response for illegal or corrupt transfers.

---
 rtl/ahb_pkg.sv | 61 ++++++
 rtl/ahb_byte_parity.sv | 18 +
 rtl/ahb_sram_slave.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types used by the SRAM slave and the upstream master.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_t;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_ERR1 = 2'b10,
    S_ERR2 = 2'b11
  } slave_state_t;

  // Byte lanes touched by a transfer of the given size at the given byte offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] byte_off);
    logic [3:0] m;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << byte_off;
      HSIZE_HALF: m = byte_off[1] ? 4'b1100 : 4'b0011;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

  // True for oversize transfers and for halfword/word transfers off their natural boundary.
  function automatic logic size_align_bad(input logic [2:0] size, input logic [1:0] byte_off);
    logic bad;
    case (size)
      HSIZE_BYTE: bad = 1'b0;
      HSIZE_HALF: bad = byte_off[0];
      HSIZE_WORD: bad = (byte_off != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb_byte_parity.sv
// Per-byte check-bit generator: bit i is set when byte i holds an even number
// of ones, so byte plus check bit always has odd weight.
module ahb_byte_parity #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [DATA_WIDTH/8-1:0] chk
);

  // Odd-parity check bit for every byte lane.
  always_comb begin
    chk = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      chk[i] = ~^data[8*i +: 8];
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-organised SRAM slave with programmable wait states,
// byte-lane writes, write-data parity checking and two-cycle ERROR response.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | ready; completes a pending data phase when dphase_q is set
//   S_WAIT | inserting wait states for an accepted OKAY transfer
//   S_ERR1 | first ERROR cycle (HREADY low, HRSP high)
//   S_ERR2 | second ERROR cycle (HREADY high, HRSP high)
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [3:0]            HWDATACHK,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADY,
  output logic                  HRSP
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  slave_state_t       state, state_d;
  logic [3:0]         wait_cnt, wait_cnt_d;
  logic               dphase_q, dphase_d;
  logic [IDX_W+1:0]   addr_q;
  logic               write_q;
  logic [2:0]         size_q;

  logic               accept;
  logic               complete;
  logic               illegal;
  logic               par_bad;
  logic               mem_we;
  logic [31:0]        word_idx;
  logic [3:0]         lane_en;
  logic [3:0]         exp_chk;
  logic [IDX_W-1:0]   mem_idx;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // HBURST is carried on the bus for debug only; HTRANS[0] does not change behaviour.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HTRANS[0]};

  assign word_idx = 32'(HADDR[ADDR_WIDTH-1:2]);
  assign illegal  = size_align_bad(HSIZE, HADDR[1:0]) || (word_idx >= 32'(MEM_DEPTH));
  assign lane_en  = lane_mask(size_q, addr_q[1:0]);
  assign mem_idx  = addr_q[IDX_W+1:2];

  ahb_byte_parity #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data(HWDATA),
    .chk (exp_chk)
  );

  // Only lanes actually written are held to the parity rule.
  assign par_bad = |((exp_chk ^ HWDATACHK) & lane_en);

  // Next-state, bus handshake and address-phase accept decision.
  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    dphase_d   = dphase_q;
    HREADY     = 1'b1;
    HRSP       = RESP_OKAY;
    complete   = 1'b0;
    accept     = 1'b0;

    case (state)
      S_IDLE: begin
        if (dphase_q) begin
          if (write_q && par_bad) begin
            // Corrupt write data: hold the bus and turn the transfer into an ERROR.
            HREADY   = 1'b0;
            state_d  = S_ERR1;
            dphase_d = 1'b0;
          end else begin
            complete = 1'b1;
            dphase_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        HREADY = 1'b0;
        if (wait_cnt == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt - 4'd1;
        end
      end
      S_ERR1: begin
        HREADY  = 1'b0;
        HRSP    = RESP_ERROR;
        state_d = S_ERR2;
      end
      S_ERR2: begin
        HRSP    = RESP_ERROR;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    accept = HREADY && HSEL && HTRANS[1];

    if (accept) begin
      if (illegal) begin
        state_d  = S_ERR1;
        dphase_d = 1'b0;
      end else if (WAIT_STATES > 0) begin
        state_d    = S_WAIT;
        wait_cnt_d = 4'(WAIT_STATES - 1);
        dphase_d   = 1'b1;
      end else begin
        state_d  = S_IDLE;
        dphase_d = 1'b1;
      end
    end
  end

  // State and address-phase pipeline registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      dphase_q <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
      dphase_q <= dphase_d;
      if (accept) begin
        addr_q  <= HADDR[IDX_W+1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

  // A reset arriving on the completing edge drops the write.
  assign mem_we = complete && write_q && !HRESET;

  // Byte-lane commit into the array; contents survive reset.
  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int i = 0; i < DATA_WIDTH / 8; i++) begin
        if (lane_en[i]) begin
          mem[mem_idx][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Read data only appears in the completing cycle of a read.
  assign HRDATA = (complete && !write_q) ? mem[mem_idx] : '0;

endmodule
